// File: rtl/muldiv_sched_if.sv
// Request/response bundle between the issue stage and the HI/LO multiply/divide sequencer.
interface muldiv_sched_if #(
    parameter int TAG_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      hi_o;
    logic [31:0]      lo_o;
    logic             busy;

    // Issue-stage side
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush,
        input  req_ready, resp_valid, resp_tag, hi_o, lo_o, busy
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush,
        output req_ready, resp_valid, resp_tag, hi_o, lo_o, busy
    );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: fixed-latency multiplier, 32-step restoring
// divider, MTHI/MTLO writes, tagged one-cycle completion pulse.
// Optional macro MULDIV_EARLY_ZERO_EN: zero-operand multiplies and zero
// dividend/divisor divides complete on the accept edge instead of running.
module muldiv_sched #(
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MULDIV_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    // 64-bit product, operands extended by signedness
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax, bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ax * bx;
    endfunction

    // One restoring step; returns {remainder, quotient-shift}
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] d);
        logic [32:0] sh, diff;
        sh   = {rem, quo[31]};
        diff = sh - {1'b0, d};
        if (!diff[32]) return {diff[31:0], quo[30:0], 1'b1};
        else           return {sh[31:0], quo[30:0], 1'b0};
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;       // raw rs (multiplicand, or dividend for /0 result)
    logic [31:0]      b_q, b_d;       // raw rt for MUL, divisor magnitude for DIV
    logic             sgn_q, sgn_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic        accept;
    logic        div_sgn;
    logic [31:0] a_mag, b_mag;
    logic [63:0] step0, step_n;
    logic [63:0] prod_req, prod_lat;
    logic [31:0] q_fix, r_fix;

    assign bus.req_ready  = (state_q == S_IDLE) && !bus.flush;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_tag   = resp_tag_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;

    assign div_sgn  = (bus.req_op == OP_DIV);
    assign a_mag    = (div_sgn && bus.req_a[31]) ? -bus.req_a : bus.req_a;
    assign b_mag    = (div_sgn && bus.req_b[31]) ? -bus.req_b : bus.req_b;
    // The first divide step is taken on the accept edge so the write lands at cycle 32
    assign step0    = div_step(32'd0, a_mag, b_mag);
    assign step_n   = div_step(rem_q, quo_q, b_q);
    assign prod_req = mul64(bus.req_a, bus.req_b, bus.req_op == OP_MULT);
    assign prod_lat = mul64(a_q, b_q, sgn_q);
    assign q_fix    = negq_q ? -quo_q : quo_q;
    assign r_fix    = negr_q ? -rem_q : rem_q;

    // Next-state, datapath and completion logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        sgn_d        = sgn_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        negq_d       = negq_q;
        negr_d       = negr_q;
        dz_d         = dz_q;
        tag_d        = tag_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tag_d = bus.req_tag;
                    case (bus.req_op)
                        OP_MULT, OP_MULTU: begin
                            a_d   = bus.req_a;
                            b_d   = bus.req_b;
                            sgn_d = (bus.req_op == OP_MULT);
                            if (EARLY_ZERO && (bus.req_a == 32'd0 || bus.req_b == 32'd0)) begin
                                hi_d         = 32'd0;
                                lo_d         = 32'd0;
                                resp_valid_d = 1'b1;
                                resp_tag_d   = bus.req_tag;
                            end else if (MUL_LAT == 1) begin
                                {hi_d, lo_d} = prod_req;
                                resp_valid_d = 1'b1;
                                resp_tag_d   = bus.req_tag;
                            end else begin
                                cnt_d   = 5'd1;
                                state_d = S_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d    = bus.req_a;
                            b_d    = b_mag;
                            negq_d = div_sgn && (bus.req_a[31] ^ bus.req_b[31]);
                            negr_d = div_sgn && bus.req_a[31];
                            dz_d   = (bus.req_b == 32'd0);
                            if (EARLY_ZERO && bus.req_b == 32'd0) begin
                                hi_d         = bus.req_a;
                                lo_d         = 32'hFFFF_FFFF;
                                resp_valid_d = 1'b1;
                                resp_tag_d   = bus.req_tag;
                            end else if (EARLY_ZERO && bus.req_a == 32'd0) begin
                                hi_d         = 32'd0;
                                lo_d         = 32'd0;
                                resp_valid_d = 1'b1;
                                resp_tag_d   = bus.req_tag;
                            end else begin
                                {rem_d, quo_d} = step0;
                                cnt_d          = 5'd1;
                                state_d        = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d         = bus.req_a;
                            resp_valid_d = 1'b1;
                            resp_tag_d   = bus.req_tag;
                        end
                        OP_MTLO: begin
                            lo_d         = bus.req_a;
                            resp_valid_d = 1'b1;
                            resp_tag_d   = bus.req_tag;
                        end
                        default: begin
                            resp_valid_d = 1'b1;
                            resp_tag_d   = bus.req_tag;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'(MUL_LAT - 1)) begin
                    {hi_d, lo_d} = prod_lat;
                    resp_valid_d = 1'b1;
                    resp_tag_d   = tag_q;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    {rem_d, quo_d} = step_n;
                    cnt_d          = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    hi_d         = dz_q ? a_q : r_fix;
                    lo_d         = dz_q ? 32'hFFFF_FFFF : q_fix;
                    resp_valid_d = 1'b1;
                    resp_tag_d   = tag_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            negq_q       <= 1'b0;
            negr_q       <= 1'b0;
            dz_q         <= 1'b0;
            tag_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sgn_q        <= sgn_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            negq_q       <= negq_d;
            negr_q       <= negr_d;
            dz_q         <= dz_d;
            tag_q        <= tag_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: arithmetic reference model plus directed vectors.
module tb_muldiv_sched;
    localparam int TAG_W   = 6;
    localparam int MUL_LAT = 3;
`ifdef MULDIV_EARLY_ZERO_EN
    localparam bit EZ = 1'b1;
`else
    localparam bit EZ = 1'b0;
`endif
    localparam int ZLAT_M = EZ ? 1 : MUL_LAT;
    localparam int ZLAT_D = EZ ? 1 : 33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_sched_if #(.TAG_W(TAG_W)) bus();
    muldiv_sched #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference results straight from the arithmetic definitions
    function automatic void golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l,
                                   output bit wh, output bit wl, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0; l = '0; wh = 1'b0; wl = 1'b0; lat = 1;
        case (op)
            3'd0, 3'd1: begin
                p = (op == 3'd0) ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
                h = p[63:32]; l = p[31:0]; wh = 1'b1; wl = 1'b1;
                lat = (EZ && (a == 0 || b == 0)) ? 1 : MUL_LAT;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (op == 3'd2) begin
                    q = sa / sb; r = sa % sb;
                    l = 32'(q); h = 32'(r);
                end else begin
                    l = a / b; h = a % b;
                end
                wh = 1'b1; wl = 1'b1;
                lat = (EZ && (a == 0 || b == 0)) ? 1 : 33;
            end
            3'd4: begin h = a; wh = 1'b1; end
            3'd5: begin l = a; wl = 1'b1; end
            default: ;
        endcase
    endfunction

    // Model state: one outstanding request with a completion cycle
    bit               pend;
    int               done_at;
    logic [31:0]      m_hi, m_lo, p_hi, p_lo;
    bit               p_wh, p_wl;
    logic [TAG_W-1:0] p_tag, m_tag;
    bit               m_rv;

    always @(posedge clk) begin : model
        bit rdy;
        int lat;
        if (reset) begin
            pend = 1'b0; m_hi = '0; m_lo = '0; m_rv = 1'b0; m_tag = '0;
        end else begin
            rdy = !pend && !bus.flush;
            if (pend && bus.flush) pend = 1'b0;
            if (rdy && bus.req_valid) begin
                golden(bus.req_op, bus.req_a, bus.req_b, p_hi, p_lo, p_wh, p_wl, lat);
                pend = 1'b1; done_at = cyc + lat; p_tag = bus.req_tag;
            end
            m_rv = 1'b0;
            if (pend && done_at == cyc + 1) begin
                if (p_wh) m_hi = p_hi;
                if (p_wl) m_lo = p_lo;
                m_rv = 1'b1; m_tag = p_tag; pend = 1'b0;
            end
        end
        cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp_valid", bus.resp_valid, m_rv);
            if (m_rv) chk("resp_tag", bus.resp_tag, m_tag);
            chk("hi_o", bus.hi_o, m_hi);
            chk("lo_o", bus.lo_o, m_lo);
            chk("busy", bus.busy, pend);
            chk("req_ready", bus.req_ready, !pend && !bus.flush);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        int acc;
        bit got;
        acc = cyc;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                chk({nm, "_lat"}, 64'(cyc - acc), 64'(lat));
                chk({nm, "_tag"}, bus.resp_tag, tag);
                chk({nm, "_hi"}, bus.hi_o, eh);
                chk({nm, "_lo"}, bus.lo_o, el);
            end
        end
        if (!got) chk({nm, "_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_rv", bus.resp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_tag", bus.resp_tag, 6'd0);
        @(posedge clk); #1;

        run_op("mult",   3'd0, 32'hFFFF_FFFE, 32'h3,          6'd5,  MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  6'd6,  MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div",    3'd2, 32'hFFFF_FFF9, 32'h2,          6'd7,  33,      32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_nd", 3'd2, 32'h7,         32'hFFFF_FFFE,  6'd8,  33,      32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu",   3'd3, 32'hFFFF_FFFF, 32'h10,         6'd9,  33,      32'h0000_000F, 32'h0FFF_FFFF);
        run_op("div_ov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  6'd10, 33,      32'h0,         32'h8000_0000);
        run_op("divu_z", 3'd3, 32'h64,        32'h0,          6'd11, ZLAT_D,  32'h64,        32'hFFFF_FFFF);
        run_op("mult_z", 3'd0, 32'h0,         32'h5,          6'd12, ZLAT_M,  32'h0,         32'h0);
        run_op("div_0n", 3'd2, 32'h0,         32'h5,          6'd13, ZLAT_D,  32'h0,         32'h0);
        run_op("rsvd",   3'd6, 32'h1111_1111, 32'h2,          6'd14, 1,       32'h0,         32'h0);

        // MTHI then MTLO back to back: completion pulse in both following cycles
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'h1234_5678; bus.req_tag = 6'd20;
        @(posedge clk); #1;
        bus.req_op = 3'd5; bus.req_a = 32'h9ABC_DEF0; bus.req_tag = 6'd21;
        @(negedge clk);
        chk("mthi_rv", bus.resp_valid, 1'b1);
        chk("mthi_tag", bus.resp_tag, 6'd20);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mtlo_rv", bus.resp_valid, 1'b1);
        chk("mtlo_hi", bus.hi_o, 32'h1234_5678);
        chk("mtlo_lo", bus.lo_o, 32'h9ABC_DEF0);
        @(posedge clk); #1;

        // Flush a divide mid-flight; HI/LO keep the MT-loaded values
        run_op("mthi2", 3'd4, 32'hAAAA_0000, 32'h0, 6'd22, 1, 32'hAAAA_0000, 32'h9ABC_DEF0);
        run_op("mtlo2", 3'd5, 32'h0000_BBBB, 32'h0, 6'd23, 1, 32'hAAAA_0000, 32'h0000_BBBB);
        bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_a = 32'h64; bus.req_b = 32'h3; bus.req_tag = 6'd24;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        #1;
        chk("flush_ready", bus.req_ready, 1'b1);
        chk("flush_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.req_valid = 1'b1;
        #1;
        chk("flush_noready", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("flush_hi", bus.hi_o, 32'hAAAA_0000);
        chk("flush_lo", bus.lo_o, 32'h0000_BBBB);
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 32'h7; bus.req_b = 32'h9; bus.req_tag = 6'd30;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_hi", bus.hi_o, 32'd0);
        chk("mrst_lo", bus.lo_o, 32'd0);
        chk("mrst_busy", bus.busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        run_op("mult_after", 3'd0, 32'hFFFF_FFF9, 32'h6, 6'd31, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
